// File: rtl/muldiv_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_unit_pkg
// Description : Shared definitions for the sequential multiply/divide unit.
//               Holds the funct3 operation encodings, the FSM state type,
//               the default operand width, and the operation-decode helpers
//               used by the unit's control logic.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_seq_unit_pkg;

    localparam int c_XLEN_DEFAULT = 32;

    // funct3 operation encodings
    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [2:0] c_OP_REMU   = 3'b111;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_CALC = 2'd1;
    localparam state_t c_ST_FIX  = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    // rs1 is treated as a signed value
    function automatic logic op_signed_a(input logic [2:0] f);
        case (f)
            c_OP_MUL, c_OP_MULH, c_OP_MULHSU, c_OP_DIV, c_OP_REM: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    // rs2 is treated as a signed value
    function automatic logic op_signed_b(input logic [2:0] f);
        case (f)
            c_OP_MUL, c_OP_MULH, c_OP_DIV, c_OP_REM: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Operation uses the shift-subtract divider
    function automatic logic op_is_div(input logic [2:0] f);
        case (f)
            c_OP_DIV, c_OP_DIVU, c_OP_REM, c_OP_REMU: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    // Divide operation that returns the quotient (as opposed to remainder)
    function automatic logic op_is_quot(input logic [2:0] f);
        case (f)
            c_OP_DIV, c_OP_DIVU: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_unit_if
// Description : Request/response bundle between a core and the sequential
//               multiply/divide unit.
//               start/kill/funct3/rs1/rs2 : core -> unit
//               busy/done/result          : unit -> core
//               master modport = core side, slave modport = unit side.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_unit_if
    import muldiv_seq_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, funct3, rs1, rs2,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_unit_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_step
// Description : Combinational single radix-2 step for the multiply/divide
//               datapath, operating on unsigned magnitudes.
//               Multiply: {i_hi,i_lo} is the 2*XLEN product/multiplier
//                 register; when i_lo[0] is set, i_operand (multiplicand) is
//                 added to the high half, then the whole register shifts right.
//               Divide  : i_hi is the partial remainder, i_lo the dividend
//                 being shifted out / quotient being shifted in; i_operand is
//                 the divisor (restoring shift-subtract).
//   i_is_div  : 1 = divide step, 0 = multiply step
//   i_hi/i_lo : current high/low register halves
//   i_operand : multiplicand (multiply) or divisor (divide)
//   o_hi/o_lo : register halves after one step
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  wire             i_is_div,
    input  wire [XLEN-1:0]  i_hi,
    input  wire [XLEN-1:0]  i_lo,
    input  wire [XLEN-1:0]  i_operand,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN+1:0] w_div_diff;

    always_comb begin
        w_addend    = i_lo[0] ? i_operand : '0;
        // One extra bit keeps the carry that shifts into the high half
        w_mul_sum   = {1'b0, i_hi} + {1'b0, w_addend};
        w_div_shift = {i_hi, i_lo[XLEN-1]};
        // Top bit of the difference is the borrow: set means restore
        w_div_diff  = {1'b0, w_div_shift} - {2'b00, i_operand};

        if (i_is_div) begin
            if (w_div_diff[XLEN+1]) begin
                o_hi = w_div_shift[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b0};
            end else begin
                // No borrow: difference is below the divisor, fits XLEN bits
                o_hi = XLEN'(w_div_diff);
                o_lo = {i_lo[XLEN-2:0], 1'b1};
            end
        end else begin
            o_hi = w_mul_sum[XLEN:1];
            o_lo = {w_mul_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_unit
// Description : Sequential RISC-V style M-extension unit. One radix-2 step
//               per cycle on operand magnitudes, sign fix-up in a final
//               cycle, one-cycle done pulse. Optional fast completion of
//               divide-by-zero and signed overflow.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of muldiv_seq_unit_if
//          (start, kill, funct3, rs1, rs2 in; busy, done, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit
    import muldiv_seq_unit_pkg::*;
#(
    parameter int XLEN      = c_XLEN_DEFAULT,
    parameter bit FAST_ZERO = 1'b1
) (
    input wire               clk,
    input wire               rst,
    muldiv_seq_unit_if.slave bus
);
    localparam int              CNT_W      = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state_q,  w_state_d;
    logic [2:0]       r_op_q,     w_op_d;
    logic [XLEN-1:0]  r_hi_q,     w_hi_d;
    logic [XLEN-1:0]  r_lo_q,     w_lo_d;
    logic [XLEN-1:0]  r_opnd_q,   w_opnd_d;
    logic             r_neg_a_q,  w_neg_a_d;
    logic             r_neg_b_q,  w_neg_b_d;
    logic             r_divz_q,   w_divz_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [XLEN-1:0]  r_fix_q,    w_fix_d;
    logic [XLEN-1:0]  r_result_q, w_result_d;

    // ------------------------------------------------------------------
    // Request decode (valid only while IDLE)
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_in_div;
    logic            w_in_neg_a;
    logic            w_in_neg_b;
    logic [XLEN-1:0] w_in_abs_a;
    logic [XLEN-1:0] w_in_abs_b;
    logic            w_in_divz;
    logic            w_in_ovf;
    logic            w_in_fast;
    logic [XLEN-1:0] w_in_special;

    always_comb begin
        w_accept   = (r_state_q == c_ST_IDLE) && bus.start && !bus.kill;
        w_in_div   = op_is_div(bus.funct3);
        w_in_neg_a = op_signed_a(bus.funct3) && bus.rs1[XLEN-1];
        w_in_neg_b = op_signed_b(bus.funct3) && bus.rs2[XLEN-1];
        w_in_abs_a = w_in_neg_a ? -bus.rs1 : bus.rs1;
        w_in_abs_b = w_in_neg_b ? -bus.rs2 : bus.rs2;
        w_in_divz  = w_in_div && (bus.rs2 == '0);
        w_in_ovf   = w_in_div && op_signed_a(bus.funct3)
                     && (bus.rs1 == c_INT_MIN) && (bus.rs2 == '1);
        w_in_fast  = FAST_ZERO && (w_in_divz || w_in_ovf);
        // Closed-form answers for the two corner cases
        if (op_is_quot(bus.funct3)) begin
            w_in_special = w_in_divz ? '1 : bus.rs1;
        end else begin
            w_in_special = w_in_divz ? bus.rs1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_step_hi;
    logic [XLEN-1:0] w_step_lo;

    mdu_iter_step #(
        .XLEN (XLEN)
    ) u_iter_step (
        .i_is_div  (op_is_div(r_op_q)),
        .i_hi      (r_hi_q),
        .i_lo      (r_lo_q),
        .i_operand (r_opnd_q),
        .o_hi      (w_step_hi),
        .o_lo      (w_step_lo)
    );

    // ------------------------------------------------------------------
    // Sign fix-up and output select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_value;

    always_comb begin
        w_prod     = {r_hi_q, r_lo_q};
        w_prod_fix = (r_neg_a_q ^ r_neg_b_q) ? -w_prod : w_prod;
        // Divide-by-zero quotient is forced; the remainder falls out of the
        // iteration naturally (the dividend shifts into the remainder).
        if (r_divz_q) begin
            w_quot_fix = '1;
        end else begin
            w_quot_fix = (r_neg_a_q ^ r_neg_b_q) ? -r_lo_q : r_lo_q;
        end
        w_rem_fix = r_neg_a_q ? -r_hi_q : r_hi_q;

        case (r_op_q)
            c_OP_MUL:                          w_fix_value = w_prod_fix[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_fix_value = w_prod_fix[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:               w_fix_value = w_quot_fix;
            default:                           w_fix_value = w_rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register (plus datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_ST_IDLE;
            r_op_q     <= '0;
            r_hi_q     <= '0;
            r_lo_q     <= '0;
            r_opnd_q   <= '0;
            r_neg_a_q  <= 1'b0;
            r_neg_b_q  <= 1'b0;
            r_divz_q   <= 1'b0;
            r_cnt_q    <= '0;
            r_fix_q    <= '0;
            r_result_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_hi_q     <= w_hi_d;
            r_lo_q     <= w_lo_d;
            r_opnd_q   <= w_opnd_d;
            r_neg_a_q  <= w_neg_a_d;
            r_neg_b_q  <= w_neg_b_d;
            r_divz_q   <= w_divz_d;
            r_cnt_q    <= w_cnt_d;
            r_fix_q    <= w_fix_d;
            r_result_q <= w_result_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = w_in_fast ? c_ST_DONE : c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                if (bus.kill) begin
                    w_state_d = c_ST_IDLE;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                w_state_d = bus.kill ? c_ST_IDLE : c_ST_DONE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_op_d     = r_op_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;
        w_opnd_d   = r_opnd_q;
        w_neg_a_d  = r_neg_a_q;
        w_neg_b_d  = r_neg_b_q;
        w_divz_d   = r_divz_q;
        w_cnt_d    = r_cnt_q;
        w_fix_d    = r_fix_q;
        w_result_d = r_result_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_op_d    = bus.funct3;
                    w_neg_a_d = w_in_neg_a;
                    w_neg_b_d = w_in_neg_b;
                    w_divz_d  = w_in_divz;
                    w_cnt_d   = '0;
                    w_hi_d    = '0;
                    // Multiply: low half holds the multiplier, operand is the
                    // multiplicand. Divide: low half holds the dividend,
                    // operand is the divisor.
                    w_lo_d    = w_in_div ? w_in_abs_a : w_in_abs_b;
                    w_opnd_d  = w_in_div ? w_in_abs_b : w_in_abs_a;
                    w_fix_d   = w_in_special;
                end
            end
            c_ST_CALC: begin
                // The cycle that sees the last count only transitions to FIX
                if (!bus.kill && (r_cnt_q != c_CNT_LAST)) begin
                    w_hi_d  = w_step_hi;
                    w_lo_d  = w_step_lo;
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            c_ST_FIX: begin
                if (!bus.kill) begin
                    w_fix_d = w_fix_value;
                end
            end
            default: begin
                // Commit only if the pulse was not flushed
                if (!bus.kill) begin
                    w_result_d = r_fix_q;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy   = (r_state_q == c_ST_CALC) || (r_state_q == c_ST_FIX);
        bus.done   = (r_state_q == c_ST_DONE) && !bus.kill;
        // During the done pulse the fresh value is shown before it is
        // committed, so a kill in DONE leaves the visible result untouched.
        bus.result = bus.done ? r_fix_q : r_result_q;
    end

endmodule
`default_nettype wire
